// File: rtl/serial_addsub_unit.sv
// -----------------------------------------------------------------------------
// serial_addsub_unit
//
// Digit-serial two's-complement adder/subtractor. An operation is launched
// from IDLE by start; the operands are then consumed DIGIT bits per clock,
// LSB slice first, with a ripple carry held in a flop between slices. After
// WIDTH/DIGIT slices the assembled sum, the carry out of the MSB and the
// signed overflow flag are loaded into the output registers. done pulses for
// one cycle, and the unit then returns to IDLE.
//
// Subtraction is a + ~b + 1: b is inverted at capture and the initial carry-in
// is set to 1.
//
// Optional feature: define SERIAL_ADDSUB_SAT_EN to make result saturate on
// signed overflow. carry and overflow always report the unsaturated values.
//
// Parameters
//   WIDTH : operand/result width, 4..64
//   DIGIT : bits processed per cycle; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : launch request, sampled only in IDLE
//   mode     : 0 = a + b, 1 = a - b, sampled with start
//   a, b     : operands, sampled with start
//   busy     : high while slices are being processed
//   done     : one-cycle completion pulse
//   result   : registered result, held until the next completion
//   carry    : carry out of the MSB (subtract: 1 = no borrow)
//   overflow : signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("serial_addsub_unit: WIDTH must be in 4..64");
  end
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub_unit: WIDTH must be an integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]         slice_sum;
  logic [WIDTH+DIGIT-1:0] shifted;
  logic [WIDTH-1:0]       full_sum;
  logic                   a_msb;
  logic                   b_msb;
  logic                   ovf_now;

`ifdef SERIAL_ADDSUB_SAT_EN
  // On overflow the true result has the sign of the (equal-signed) operands,
  // so that sign selects the clamp value.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] sum,
                                                  input logic             ovf,
                                                  input logic             sign);
    logic [WIDTH-1:0] r;
    r = sum;
    if (ovf) begin
      if (sign) r = {1'b1, {(WIDTH-1){1'b0}}};
      else      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    slice_sum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, cin_q};

    // The new slice enters at the top of the shift register; after N slices
    // the LSB slice has travelled down to bit 0.
    shifted  = {slice_sum[DIGIT-1:0], sr_q};
    full_sum = shifted[WIDTH+DIGIT-1:DIGIT];

    // On the last slice the top bit of each operand slice is the operand MSB.
    a_msb   = opa_q[DIGIT-1];
    b_msb   = opb_q[DIGIT-1];
    ovf_now = (a_msb == b_msb) && (full_sum[WIDTH-1] != a_msb);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          opa_d   = a;
          opb_d   = mode ? ~b : b;
          cin_d   = mode;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      BUSY: begin
        opa_d = opa_q >> DIGIT;
        opb_d = opb_q >> DIGIT;
        cin_d = slice_sum[DIGIT];
        sr_d  = full_sum;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_SAT_EN
          result_d = sat_result(full_sum, ovf_now, a_msb);
`else
          result_d = full_sum;
`endif
          carry_d = slice_sum[DIGIT];
          ovf_d   = ovf_now;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
